// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus request/response types and responder constants.
// Imported by dbus_sram_responder and dbus_ram_array.
package dbus_sram_responder_pkg;

  localparam int DBUS_RESP_MAX_LATENCY = 15;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } dresp_state_e;

endpackage

// File: rtl/dbus_ram_array.sv
// DEPTH x 32 single-port RAM, byte-enable write, registered read.
// Ports: clk, en_i, we_i (byte enables), idx_i, wdata_i, rdata_o.
module dbus_ram_array #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Read returns the pre-write word; output holds until next enable.
  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_o <= mem_q[idx_i];
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus responder: word RAM answering after a fixed LATENCY.
// Ports: clk, resetn, dreq in, dresp out. Option: DBUS_RESP_STALL_EN.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter int          LATENCY    = 1,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dresp_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         data_ok;
  logic         addr_ok;
  logic         accept;
  logic         stall;
  logic [31:0]  ram_rdata;

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13]
                 ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  assign stall = lfsr_q[0];
`else
  logic unused_seed;
  assign unused_seed = ^STALL_SEED;
  assign stall = 1'b0;
`endif

  always_comb begin
    data_ok = (state_q == S_BUSY) && (cnt_q == 4'd0);
    // resetn term keeps addr_ok low while reset is held.
    addr_ok = resetn && !stall &&
              ((state_q == S_IDLE) || data_ok);
    accept  = dreq.valid && addr_ok;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (accept) begin
          cnt_d = CNT_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  dbus_ram_array #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .en_i   (accept),
    .we_i   (dreq.strobe),
    .idx_i  (dreq.addr[IW+1:2]),
    .wdata_i(dreq.data),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = addr_ok;
    dresp.data_ok = data_ok;
    dresp.data    = data_ok ? ram_rdata : 32'h0;
  end

  logic unused_req;
  assign unused_req = ^{dreq.size,
                        dreq.addr[31:IW+2],
                        dreq.addr[1:0]};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed + scoreboard bench for dbus_sram_responder.
// Two instances: LATENCY=1 and LATENCY=3.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  dbus_req_t  dreq1, dreq3;
  dbus_resp_t dresp1, dresp3;
  int         n_chk = 0;
  int         n_fail = 0;

  dbus_sram_responder #(
    .DEPTH(1024), .LATENCY(1)
  ) u_l1 (
    .clk(clk), .resetn(resetn),
    .dreq(dreq1), .dresp(dresp1)
  );

  dbus_sram_responder #(
    .DEPTH(1024), .LATENCY(3)
  ) u_l3 (
    .clk(clk), .resetn(resetn),
    .dreq(dreq3), .dresp(dresp3)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic dbus_req_t mk(input logic v,
                                   input logic [31:0] a,
                                   input logic [3:0] s,
                                   input logic [31:0] d);
    dbus_req_t r;
    r        = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = MSIZE4;
    r.strobe = s;
    r.data   = d;
    return r;
  endfunction

  function automatic dbus_resp_t rsp(input int sel);
    return (sel == 3) ? dresp3 : dresp1;
  endfunction

  task automatic drive(input int sel, input dbus_req_t r);
    if (sel == 3) dreq3 = r;
    else dreq1 = r;
  endtask

  task automatic do_req(input int sel,
                        input logic [31:0] a,
                        input logic [3:0] s,
                        input logic [31:0] d,
                        output logic [31:0] rd);
    int n;
    int lat;
    dbus_resp_t r;
    drive(sel, mk(1'b1, a, s, d));
    n = 0;
    r = rsp(sel);
    while (!r.addr_ok && n < 100) begin
      tick;
      n++;
      r = rsp(sel);
    end
    check("accept_wait", 32'(n < 100), 32'd1);
    @(posedge clk);
    tick;
    drive(sel, mk(1'b0, 32'h0, 4'h0, 32'h0));
    lat = 1;
    r = rsp(sel);
    while (!r.data_ok && lat < 40) begin
      tick;
      lat++;
      r = rsp(sel);
    end
    check("latency", 32'(lat), (sel == 3) ? 32'd3 : 32'd1);
    rd = r.data;
  endtask

  logic [31:0] mdl [16];
  logic [31:0] rd;
  logic [31:0] a;
  logic [31:0] d;
  logic [3:0]  s;
  int          idx;
  int          n_ops;
  logic        saw;
  int          nw;

  initial begin
    dreq1 = '0;
    dreq3 = '0;
    resetn = 1'b0;
    repeat (2) tick;
    check("rst_addr_ok", 32'(dresp1.addr_ok), 32'd0);
    check("rst_data_ok", 32'(dresp1.data_ok), 32'd0);
    check("rst_data", dresp1.data, 32'h0);
    resetn = 1'b1;
    tick;
`ifndef DBUS_RESP_STALL_EN
    check("idle_addr_ok", 32'(dresp3.addr_ok), 32'd1);

    // Store then load, back to back, LATENCY=1.
    drive(1, mk(1'b1, 32'h40, 4'hF, 32'hDEADBEEF));
    check("t1_aok0", 32'(dresp1.addr_ok), 32'd1);
    tick;
    check("t1_dok1", 32'(dresp1.data_ok), 32'd1);
    check("t1_aok1", 32'(dresp1.addr_ok), 32'd1);
    drive(1, mk(1'b1, 32'h40, 4'h0, 32'h0));
    tick;
    check("t1_dok2", 32'(dresp1.data_ok), 32'd1);
    check("t1_data", dresp1.data, 32'hDEADBEEF);
    drive(1, mk(1'b0, 32'h0, 4'h0, 32'h0));
    tick;
    check("t1_dok_off", 32'(dresp1.data_ok), 32'd0);
    check("t1_data_off", dresp1.data, 32'h0);
    check("t1_aok_idle", 32'(dresp1.addr_ok), 32'd1);
`else
    do_req(1, 32'h40, 4'hF, 32'hDEADBEEF, rd);
    do_req(1, 32'h40, 4'h0, 32'h0, rd);
    check("t1_data", rd, 32'hDEADBEEF);
`endif

    // Byte store over a full word.
    do_req(1, 32'h40, 4'hF, 32'h11223344, rd);
    do_req(1, 32'h41, 4'b0010, 32'h0000AA00, rd);
    check("t2_rbw", rd, 32'h11223344);
    do_req(1, 32'h40, 4'h0, 32'h0, rd);
    check("t2_merge", rd, 32'h1122AA44);

    // LATENCY=3 timing with a held second request.
    do_req(3, 32'h80, 4'hF, 32'hCAFEF00D, rd);
`ifndef DBUS_RESP_STALL_EN
    drive(3, mk(1'b1, 32'h80, 4'h0, 32'h0));
    check("t3_aok_T", 32'(dresp3.addr_ok), 32'd1);
    tick;
    check("t3_aok_T1", 32'(dresp3.addr_ok), 32'd0);
    check("t3_dok_T1", 32'(dresp3.data_ok), 32'd0);
    drive(3, mk(1'b1, 32'h84, 4'h0, 32'h0));
    tick;
    check("t3_aok_T2", 32'(dresp3.addr_ok), 32'd0);
    check("t3_dok_T2", 32'(dresp3.data_ok), 32'd0);
    tick;
    check("t3_dok_T3", 32'(dresp3.data_ok), 32'd1);
    check("t3_data_T3", dresp3.data, 32'hCAFEF00D);
    check("t3_aok_T3", 32'(dresp3.addr_ok), 32'd1);
    tick;
    drive(3, mk(1'b0, 32'h0, 4'h0, 32'h0));
    check("t3_b2b_1", 32'(dresp3.data_ok), 32'd0);
    tick;
    check("t3_b2b_2", 32'(dresp3.data_ok), 32'd0);
    tick;
    check("t3_b2b_3", 32'(dresp3.data_ok), 32'd1);
    tick;
`else
    do_req(3, 32'h80, 4'h0, 32'h0, rd);
    check("t3_data", rd, 32'hCAFEF00D);
`endif

    // Upper address bits alias onto the same word.
    do_req(3, 32'h1000_0010, 4'hF, 32'h5A5A1234, rd);
    do_req(3, 32'h0000_0010, 4'h0, 32'h0, rd);
    check("t4_alias_hi", rd, 32'h5A5A1234);
    do_req(3, 32'h0000_1000, 4'hF, 32'h0F0F0F0F, rd);
    do_req(3, 32'h0000_0000, 4'h0, 32'h0, rd);
    check("t4_wrap", rd, 32'h0F0F0F0F);

    // Reset in the cycle after an accept.
    drive(3, mk(1'b1, 32'h80, 4'h0, 32'h0));
    nw = 0;
    while (!dresp3.addr_ok && nw < 100) begin
      tick;
      nw++;
    end
    @(posedge clk);
    #1;
    resetn = 1'b0;
    drive(3, mk(1'b0, 32'h0, 4'h0, 32'h0));
    #1;
    check("t5_rst_dok", 32'(dresp3.data_ok), 32'd0);
    check("t5_rst_aok", 32'(dresp3.addr_ok), 32'd0);
    tick;
    tick;
    resetn = 1'b1;
`ifndef DBUS_RESP_STALL_EN
    #1;
    check("t5_aok_rel", 32'(dresp3.addr_ok), 32'd1);
`endif
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (dresp3.data_ok) saw = 1'b1;
    end
    check("t5_no_dok", 32'(saw), 32'd0);
    do_req(3, 32'h80, 4'h0, 32'h0, rd);
    check("t5_keep3", rd, 32'hCAFEF00D);
    do_req(1, 32'h40, 4'h0, 32'h0, rd);
    check("t5_keep1", rd, 32'h1122AA44);

    // Random traffic against a word model.
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      do_req(1, 32'(i * 4), 4'hF, d, rd);
      mdl[i] = d;
    end
`ifdef DBUS_RESP_STALL_EN
    n_ops = 1000;
`else
    n_ops = 300;
`endif
    for (int k = 0; k < n_ops; k++) begin
      idx = $urandom_range(15);
      if ($urandom_range(1) == 0) s = 4'h0;
      else s = 4'($urandom_range(15));
      d = $urandom;
      a = ($urandom & 32'hFFFF_F000)
        | 32'(idx * 4)
        | 32'($urandom_range(3));
      do_req(1, a, s, d, rd);
      check("t6_data", rd, mdl[idx]);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      end
    end

    tick;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
